// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and sizes for the 8:1 mux scan sequencer.
// The optional parity output is enabled with MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_e;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Request/select/result bundle between the scan sequencer and its neighbours.
// The parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_sequencer_if;
   import mux_scan_pkg::*;

   logic              start;
   logic              abort;
   logic              y_in;
   logic              s0;
   logic              s1;
   logic              s2;
   logic              busy;
   logic [NUM_CH-1:0] data_out;
   logic              valid;
`ifdef MUX_SCAN_PARITY_EN
   logic              parity;
`endif

   modport master (
      output start, abort, y_in,
      input  s0, s1, s2, busy, data_out, valid
`ifdef MUX_SCAN_PARITY_EN
      , input parity
`endif
   );

   modport slave (
      input  start, abort, y_in,
      output s0, s1, s2, busy, data_out, valid
`ifdef MUX_SCAN_PARITY_EN
      , output parity
`endif
   );

endinterface

// File: rtl/mux_scan_settle_cnt.sv
// Settle-time down-counter: load presets SETTLE_CYCLES-1, tc flags the last
// settle cycle of a channel.
module mux_scan_settle_cnt
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 8:1 mux select through channels 0..7, samples Y after a settle
// time and emits the assembled byte; MUX_SCAN_PARITY_EN adds a parity bit.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_scan_sequencer_if.slave   bus
);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q;
   logic [NUM_CH-1:0] cap_q, cap_smp, data_q;
   logic              cnt_load, cnt_en, cnt_tc;
   logic              sel_clr, sel_inc, cap_clr, cap_we, data_load;
`ifdef MUX_SCAN_PARITY_EN
   logic              parity_q;
`endif

   mux_scan_settle_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      sel_clr   = 1'b0;
      sel_inc   = 1'b0;
      cap_clr   = 1'b0;
      cap_we    = 1'b0;
      data_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = SETTLE;
               cnt_load = 1'b1;
               sel_clr  = 1'b1;
               cap_clr  = 1'b1;
            end
         end
         SETTLE: begin
            if (bus.abort) begin
               state_d = IDLE;
               sel_clr = 1'b1;
               cap_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
               if (cnt_tc) state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            // Abort wins over the capture of the current channel.
            if (bus.abort) begin
               state_d = IDLE;
               sel_clr = 1'b1;
               cap_clr = 1'b1;
            end else begin
               cap_we = 1'b1;
               if (sel_q == SEL_W'(NUM_CH - 1)) begin
                  data_load = 1'b1;
                  state_d   = DONE;
               end else begin
                  sel_inc  = 1'b1;
                  cnt_load = 1'b1;
                  state_d  = SETTLE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            sel_clr = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture image including the bit being sampled this cycle.
   always_comb begin
      cap_smp        = cap_q;
      cap_smp[sel_q] = bus.y_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q  <= '0;
         cap_q  <= '0;
         data_q <= '0;
      end else begin
         if (sel_clr)      sel_q <= '0;
         else if (sel_inc) sel_q <= sel_q + SEL_W'(1);
         if (cap_clr)      cap_q <= '0;
         else if (cap_we)  cap_q <= cap_smp;
         if (data_load)    data_q <= cap_smp;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else if (data_load) begin
         parity_q <= ^cap_smp;
      end
   end

   assign bus.parity = parity_q;
`endif

   assign bus.s0       = sel_q[0];
   assign bus.s1       = sel_q[1];
   assign bus.s2       = sel_q[2];
   assign bus.busy     = (state_q != IDLE);
   assign bus.valid    = (state_q == DONE);
   assign bus.data_out = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: behavioural 8:1 mux per instance (S=1 and S=3),
// scoreboard of expected bytes and valid cycles; parity checked with MUX_SCAN_PARITY_EN.
module tb_mux_scan_sequencer;
   import mux_scan_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_scan_sequencer_if i1 ();
   mux_scan_sequencer_if i3 ();

   logic [7:0] mux1 = 8'h00;
   logic [7:0] mux3 = 8'h00;
   assign i1.y_in = mux1[{i1.s2, i1.s1, i1.s0}];
   assign i3.y_in = mux3[{i3.s2, i3.s1, i3.s0}];

   mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
   mux_scan_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         at;
   } sb_t;

   typedef struct {
      logic [7:0] pat;
      logic [7:0] exp_d;
      logic       exp_p;
   } vec_t;

   sb_t  q1[$];
   sb_t  q3[$];
   sb_t  e1, e3;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Valid monitors: every strobe must match the oldest expected scan.
   always @(negedge clk) begin
      if (i1.valid === 1'b1) begin
         if (q1.size() == 0) begin
            check("valid1_unexpected", 32'(i1.valid), 32'd0);
         end else begin
            e1 = q1.pop_front();
            check("data1", 32'(i1.data_out), 32'(e1.data));
            check("valid1_cycle", 32'(cyc), 32'(e1.at));
`ifdef MUX_SCAN_PARITY_EN
            check("parity1", 32'(i1.parity), 32'(e1.par));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (i3.valid === 1'b1) begin
         if (q3.size() == 0) begin
            check("valid3_unexpected", 32'(i3.valid), 32'd0);
         end else begin
            e3 = q3.pop_front();
            check("data3", 32'(i3.data_out), 32'(e3.data));
            check("valid3_cycle", 32'(cyc), 32'(e3.at));
`ifdef MUX_SCAN_PARITY_EN
            check("parity3", 32'(i3.parity), 32'(e3.par));
`endif
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy1"}, 32'(i1.busy), 32'd0);
      check({tag, "_valid1"}, 32'(i1.valid), 32'd0);
      check({tag, "_data1"}, 32'(i1.data_out), 32'd0);
      check({tag, "_sel1"}, 32'({i1.s2, i1.s1, i1.s0}), 32'd0);
      check({tag, "_busy3"}, 32'(i3.busy), 32'd0);
      check({tag, "_data3"}, 32'(i3.data_out), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
      check({tag, "_parity1"}, 32'(i1.parity), 32'd0);
      check({tag, "_parity3"}, 32'(i3.parity), 32'd0);
`endif
   endtask

   // One full scan on instance d (1 or 3); with_abort raises abort in the
   // starting IDLE cycle and in DONE, where it must have no effect.
   task automatic run_scan(input int d, input logic [7:0] pat, input logic [7:0] exp_d,
                           input logic exp_p, input bit with_abort);
      int         s;
      int         per;
      sb_t        e;
      logic [2:0] sel;
      logic       bsy;
      s   = (d == 1) ? 1 : 3;
      per = 8 * (s + 1);
      @(negedge clk);
      if (d == 1) begin
         mux1 = pat; i1.start = 1'b1; i1.abort = with_abort;
      end else begin
         mux3 = pat; i3.start = 1'b1; i3.abort = with_abort;
      end
      @(posedge clk);
      #1;
      e.data = exp_d;
      e.par  = exp_p;
      e.at   = cyc + per;
      if (d == 1) q1.push_back(e);
      else        q3.push_back(e);
      for (int n = 1; n <= per + 2; n++) begin
         @(negedge clk);
         if (n == 1) begin
            i1.start = 1'b0; i3.start = 1'b0; i1.abort = 1'b0; i3.abort = 1'b0;
         end
         if (with_abort && n == per + 1) begin
            if (d == 1) i1.abort = 1'b1;
            else        i3.abort = 1'b1;
         end
         if (n == per + 2) begin
            i1.abort = 1'b0; i3.abort = 1'b0;
         end
         sel = (d == 1) ? {i1.s2, i1.s1, i1.s0} : {i3.s2, i3.s1, i3.s0};
         bsy = (d == 1) ? i1.busy : i3.busy;
         if (n <= per)
            check($sformatf("sel%0d_c%0d", d, n), 32'(sel), 32'((n - 1) / (s + 1)));
         if (n == per + 2)
            check($sformatf("sel%0d_idle", d), 32'(sel), 32'd0);
         check($sformatf("busy%0d_c%0d", d, n), 32'(bsy), (n <= per + 1) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hA5, 8'hA5, 1'b0};
      vecs[1] = '{8'h08, 8'h08, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'h3C, 8'h3C, 1'b0};
      vecs[5] = '{8'h81, 8'h81, 1'b0};
      vecs[6] = '{8'h7F, 8'h7F, 1'b1};
      vecs[7] = '{8'hA5, 8'hA5, 1'b0};

      i1.start = 1'b0; i1.abort = 1'b0;
      i3.start = 1'b0; i3.abort = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_scan(1, vecs[i].pat, vecs[i].exp_d, vecs[i].exp_p, 1'b0);

      run_scan(3, 8'hFF, 8'hFF, 1'b0, 1'b0);
      run_scan(3, 8'h5A, 8'h5A, 1'b0, 1'b0);

      // Start and abort together in IDLE starts; abort in DONE is ignored.
      run_scan(1, 8'h01, 8'h01, 1'b1, 1'b1);
      run_scan(1, 8'hA5, 8'hA5, 1'b0, 1'b0);

      // Abort during cycle 7 (channel 3 settle): no valid, data kept.
      @(negedge clk);
      mux1 = 8'hFF;
      i1.start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) i1.start = 1'b0;
         if (n == 7) i1.abort = 1'b1;
      end
      i1.abort = 1'b0;
      check("abort_busy", 32'(i1.busy), 32'd0);
      check("abort_sel", 32'({i1.s2, i1.s1, i1.s0}), 32'd0);
      check("abort_data", 32'(i1.data_out), 32'hA5);
      repeat (20) @(negedge clk);
      check("abort_data_hold", 32'(i1.data_out), 32'hA5);
      check("abort_busy_hold", 32'(i1.busy), 32'd0);
      run_scan(1, 8'h3C, 8'h3C, 1'b0, 1'b0);

      // Start pulses while busy (and in DONE) are ignored.
      @(negedge clk);
      mux1 = 8'h08;
      i1.start = 1'b1;
      @(posedge clk);
      #1;
      q1.push_back('{8'h08, 1'b1, cyc + 16});
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         i1.start = (n == 5 || n == 16 || n == 17);
         if (n == 17) check("pulse_busy_done", 32'(i1.busy), 32'd1);
      end
      i1.start = 1'b0;
      check("pulse_busy_idle", 32'(i1.busy), 32'd0);
      repeat (20) @(negedge clk);
      check("pulse_one_valid", 32'(q1.size()), 32'd0);

      // Start held high: back-to-back scans every 18 cycles.
      @(negedge clk);
      mux1 = 8'h08;
      i1.start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         q1.push_back('{8'h08, 1'b1, cyc + 16 + 18 * k});
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 40) i1.start = 1'b0;
      end
      check("held_all_valids", 32'(q1.size()), 32'd0);
      check("held_busy_end", 32'(i1.busy), 32'd0);

      // Asynchronous reset in cycle 5 of a scan.
      @(negedge clk);
      mux1 = 8'hA5;
      i1.start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         if (n == 1) i1.start = 1'b0;
      end
      check("pre_rst_busy", 32'(i1.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_busy", 32'(i1.busy), 32'd0);
         check("post_rst_valid", 32'(i1.valid), 32'd0);
      end

      check("sb1_empty", 32'(q1.size()), 32'd0);
      check("sb3_empty", 32'(q3.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
